adder_arbiter: RTL and testbench

Round-robin controller that shares one `adder` instance (n-bit, ports A, B, Y) among four requesters. Each requester presents two operands with a valid/ready handshake. The block grants one requester at a time, registers the operands, drives the shared adder, and returns the registered sum with requester ID, carry and signed-overflow flags on a single response channel with backpressure. It sits between the execute-stage clients (PC incrementer, branch-target calc, ALU add path, load/store address gen) and the single physical adder.

---
 rtl/adder_arbiter.sv | 173 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one n-bit adder among four requesters.
//
// The arbiter grants one requester at a time in round-robin order and
// registers its operands. It then drives the shared adder and returns the
// registered sum, with carry and signed-overflow flags, on one response
// channel that supports backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [3:0]     per-requester request valid
//   req_a      [4*n-1:0] packed operand A, requester i at [i*n +: n]
//   req_b      [4*n-1:0] packed operand B, same packing
//   req_ready  [3:0]     one-hot grant/accept (combinational, IDLE only)
//   rsp_valid            registered response valid
//   rsp_ready            consumer accepts response
//   rsp_id     [1:0]     index of the requester that owns the response
//   rsp_y      [n-1:0]   sum A+B mod 2^n
//   rsp_carry            unsigned carry out of bit n-1
//   rsp_ovf              signed overflow
//   busy                 high whenever the arbiter is not idle

// Shared combinational adder: Y = A + B mod 2^n.
module adder #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Y
);

  assign Y = A + B;

endmodule

module adder_arbiter #(
  parameter int unsigned n = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req_valid,
  input  logic [4*n-1:0] req_a,
  input  logic [4*n-1:0] req_b,
  output logic [3:0]     req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_id,
  output logic [n-1:0]   rsp_y,
  output logic           rsp_carry,
  output logic           rsp_ovf,
  output logic           busy
);

  typedef enum logic [1:0] {StIdle, StAdd, StResp} state_e;

  state_e       state_q, state_d;
  logic [1:0]   rr_ptr_q;
  logic [n-1:0] op_a_q, op_b_q;
  logic [1:0]   owner_q;
  logic         rsp_valid_q;
  logic [1:0]   rsp_id_q;
  logic [n-1:0] rsp_y_q;
  logic         rsp_carry_q, rsp_ovf_q;

  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [1:0]   cand;
  logic         load_op, load_rsp, clr_rsp;
  logic [n-1:0] sum;

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to rr_ptr_q is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 4'b0000;
    load_op   = 1'b0;
    load_rsp  = 1'b0;
    clr_rsp   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so no grant is advertised while reset is held.
        if (grant_valid && rst_n) begin
          req_ready = 4'b0001 << grant_idx;
          load_op   = 1'b1;
          state_d   = StAdd;
        end
      end
      StAdd: begin
        load_rsp = 1'b1;
        state_d  = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          clr_rsp = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  adder #(
    .n(n)
  ) u_adder (
    .A(op_a_q),
    .B(op_b_q),
    .Y(sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      owner_q  <= 2'd0;
    end else if (load_op) begin
      rr_ptr_q <= grant_idx + 2'd1;
      op_a_q   <= req_a[32'(grant_idx) * n +: n];
      op_b_q   <= req_b[32'(grant_idx) * n +: n];
      owner_q  <= grant_idx;
    end
  end

  // The payload is only written on the ADD edge. It keeps its value after the
  // handshake, so only rsp_valid is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_y_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else if (load_rsp) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= owner_q;
      rsp_y_q     <= sum;
      // The mod-2^n sum wrapped iff it is smaller than either operand.
      rsp_carry_q <= (sum < op_a_q);
      rsp_ovf_q   <= (op_a_q[n-1] == op_b_q[n-1]) && (sum[n-1] != op_a_q[n-1]);
    end else if (clr_rsp) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter. A transaction-level model predicts grants and
// responses; it is checked against the DUT on every falling clock edge.
// Directed sequences add literal expectations on top of that.
module tb_adder_arbiter;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req_valid = '0;
  logic [4*N-1:0] req_a = '0;
  logic [4*N-1:0] req_b = '0;
  logic [3:0]     req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [N-1:0]   rsp_y;
  logic           rsp_carry, rsp_ovf, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_arbiter #(
    .n(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_y    (rsp_y),
    .rsp_carry(rsp_carry),
    .rsp_ovf  (rsp_ovf),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester at or after ptr, wrapping; -1 when none.
  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Transaction model: an accepted op becomes a visible response one edge
  // later and stays until it is consumed. No grant happens while an op is
  // outstanding.
  int           m_ptr = 0;
  bit           m_pending = 0, m_rsp_valid = 0;
  int           m_id = 0, p_id = 0;
  logic [N-1:0] m_y = '0, p_y = '0;
  bit           m_c = 0, m_o = 0, p_c = 0, p_o = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int           g;
    logic [N:0]   s;
    longint       ss;
    logic [N-1:0] a, b;
    if (!rst_n) begin
      m_ptr <= 0; m_pending <= 0; m_rsp_valid <= 0;
      m_id <= 0; m_y <= '0; m_c <= 0; m_o <= 0;
    end else if (m_pending) begin
      m_pending <= 0; m_rsp_valid <= 1;
      m_id <= p_id; m_y <= p_y; m_c <= p_c; m_o <= p_o;
    end else if (m_rsp_valid) begin
      if (rsp_ready) m_rsp_valid <= 0;
    end else begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        a  = req_a[g*N +: N];
        b  = req_b[g*N +: N];
        s  = {1'b0, a} + {1'b0, b};
        ss = longint'($signed(a)) + longint'($signed(b));
        p_id <= g;
        p_y  <= s[N-1:0];
        p_c  <= s[N];
        // The true signed sum fits in N bits iff bits 63..31 are all equal.
        p_o  <= ((ss >>> 31) != 0) && ((ss >>> 31) != -1);
        m_ptr <= (g + 1) % 4;
        m_pending <= 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] exp_rdy;
    int g;
    exp_rdy = '0;
    if (rst_n && !m_pending && !m_rsp_valid) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_pending || m_rsp_valid);
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_y", rsp_y, m_y);
    chk("rsp_carry", rsp_carry, m_c);
    chk("rsp_ovf", rsp_ovf, m_o);
  end

  // Single-requester op with rsp_ready high; entered and left one step after
  // a rising edge while idle.
  task automatic single(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] y, input logic c, input logic o,
                        input string tag);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid = 4'b0001 << i;
    #1 chk({tag, "_ready"}, req_ready, 4'b0001 << i);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_id"}, rsp_id, i);
    chk({tag, "_y"}, rsp_y, y);
    chk({tag, "_carry"}, rsp_carry, c);
    chk({tag, "_ovf"}, rsp_ovf, o);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int ids[$];
    #22 rst_n = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_y", rsp_y, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;

    single(2, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, "one");
    single(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, "carry");
    single(1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, "ovf");
    single(3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, "novf");
    single(0, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0, "p0");

    // Pointer now 1: with 0 and 3 both valid, 3 wins, then 0.
    req_a[3*N +: N] = 32'd100; req_b[3*N +: N] = 32'd1;
    req_a[0*N +: N] = 32'd200; req_b[0*N +: N] = 32'd2;
    req_valid = 4'b1001;
    #1 chk("skip_ready3", req_ready, 4'b1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("skip_id3", rsp_id, 3);
    chk("skip_y3", rsp_y, 101);
    @(posedge clk); #1;
    chk("skip_ready0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    chk("skip_id0", rsp_id, 0);
    chk("skip_y0", rsp_y, 202);
    @(posedge clk); #1;

    // Backpressure: the response holds while requester 1 waits ungranted.
    rsp_ready = 1'b0;
    req_a[2*N +: N] = 32'd2;  req_b[2*N +: N] = 32'd3;
    req_a[1*N +: N] = 32'd10; req_b[1*N +: N] = 32'd20;
    req_valid = 4'b0100;
    #1 chk("bp_ready", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = 4'b0010;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_y", rsp_y, 5);
      chk("bp_hold_id", rsp_id, 2);
      chk("bp_hold_ready", req_ready, 4'b0000);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", req_ready, 4'b0000);
    @(posedge clk); #1;
    chk("bp_next_grant", req_ready, 4'b0010);
    req_a[1*N +: N] = 32'd2; req_b[1*N +: N] = 32'd3;
    rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    chk("bp2_y", rsp_y, 5);
    chk("bp2_id", rsp_id, 1);

    // Reset while a response is being held: everything clears at once.
    req_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_y", rsp_y, 0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    chk("mid_rst_id", rsp_id, 0);

    // Round robin from a fresh pointer with all four continuously valid.
    for (int i = 0; i < 4; i++) begin
      req_a[i*N +: N] = 32'(i * 100 + 1);
      req_b[i*N +: N] = 32'(i);
    end
    rsp_ready = 1'b1;
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_grant", req_ready, 4'b0001);
    for (int c = 1; c < 15; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) ids.push_back(int'(rsp_id));
    end
    chk("rr_count", ids.size(), 5);
    for (int k = 0; k < ids.size() && k < 5; k++) chk("rr_id", ids[k], k % 4);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("final_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
